// File: rtl/riscv_irq_ctrl_pkg.sv
// Shared types and constants for the core-facing interrupt controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package riscv_irq_ctrl_pkg;

  // Id width is fixed by the core's irq_id ports; 32 sources fill it exactly.
  localparam int ID_W    = 5;
  localparam int MAX_SRC = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } irq_state_e;

endpackage

// File: rtl/riscv_irq_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder over the enabled pending vector.
// Latency: purely combinational.
// Backpressure: none; output follows the request vector.
module irq_prio_enc #(
  parameter int N  = 32,
  parameter int IW = 5
) (
  input  logic [N-1:0]  req_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/riscv_irq_ctrl.sv
// Latches sources into sticky pending bits and presents one masked id to the core.
// Latency: source sampled at E0 -> pending after E0 -> irq_o after E1; next irq 2 cycles after ack.
// Backpressure: irq_o/irq_id_o hold until a matching ack, a retract (mask drop) or reset.
module riscv_irq_ctrl
  import riscv_irq_ctrl_pkg::*;
#(
  parameter int          N_SRC     = 32,
  parameter logic [31:0] EDGE_MASK = 32'h0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [N_SRC-1:0]  src_i,
  input  logic [N_SRC-1:0]  mask_i,
  output logic              irq_o,
  output logic [ID_W-1:0]   irq_id_o,
  input  logic              irq_ack_i,
  input  logic [ID_W-1:0]   irq_ack_id_i,
  output logic [N_SRC-1:0]  pending_o,
  output logic              spurious_o
);

  localparam logic [N_SRC-1:0] EDGE_EN = EDGE_MASK[N_SRC-1:0];

  irq_state_e        state_q, state_d;
  logic [N_SRC-1:0]  src_q;
  logic [N_SRC-1:0]  pending_q, pending_d;
  logic [N_SRC-1:0]  set_vec, clr_vec, cand;
  logic              irq_q, irq_d;
  logic [ID_W-1:0]   irq_id_q, irq_id_d;
  logic              spurious_q, spurious_d;
  logic              win_vld;
  logic [ID_W-1:0]   win_id;
  logic              cur_en;
  logic              ack_hit;

  // Pending update: edge sources need a fresh 0->1, level sources pend while high;
  // ack clears its bit but a same-cycle set wins. Out-of-range ack ids match no bit.
  always_comb begin
    set_vec = src_i & (~src_q | ~EDGE_EN);
    clr_vec = '0;
    cur_en  = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (irq_ack_i && (irq_ack_id_i == ID_W'(i))) clr_vec[i] = 1'b1;
      if (irq_id_q == ID_W'(i)) cur_en = mask_i[i];
    end
    pending_d = (pending_q & ~clr_vec) | set_vec;
    cand      = pending_q & mask_i;
  end

  irq_prio_enc #(.N(N_SRC), .IW(ID_W)) u_prio (
    .req_i   (cand),
    .valid_o (win_vld),
    .idx_o   (win_id)
  );

  // Request FSM: only an ack naming the presented id retires it; a mismatched
  // ack is flagged spurious and leaves the request up.
  always_comb begin
    state_d    = state_q;
    irq_d      = irq_q;
    irq_id_d   = irq_id_q;
    ack_hit    = irq_ack_i && (state_q == REQ) && (irq_ack_id_i == irq_id_q);
    spurious_d = irq_ack_i && !ack_hit;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d  = REQ;
          irq_d    = 1'b1;
          irq_id_d = win_id;
        end
      end
      REQ: begin
        if (ack_hit) begin
          state_d = GAP;
          irq_d   = 1'b0;
        end else if (!cur_en) begin
          state_d = IDLE;
          irq_d   = 1'b0;
        end
      end
      GAP: begin
        state_d = IDLE;
        irq_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything including src history.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      src_q      <= '0;
      pending_q  <= '0;
      irq_q      <= 1'b0;
      irq_id_q   <= '0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_i;
      pending_q  <= pending_d;
      irq_q      <= irq_d;
      irq_id_q   <= irq_id_d;
      spurious_q <= spurious_d;
    end
  end

  assign irq_o      = irq_q;
  assign irq_id_o   = irq_id_q;
  assign pending_o  = pending_q;
  assign spurious_o = spurious_q;

endmodule

// File: tb/tb_riscv_irq_ctrl.sv
// Bench for riscv_irq_ctrl: directed scenarios plus randomized traffic against a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_riscv_irq_ctrl;

  localparam int          N    = 32;
  localparam logic [31:0] EDGE = 32'hFFFF_FFFE;  // source 0 level, all others edge

  logic        clk;
  logic        rst_n;
  logic [31:0] src;
  logic [31:0] mask;
  logic        irq;
  logic [4:0]  irq_id;
  logic        ack;
  logic [4:0]  ack_id;
  logic [31:0] pending;
  logic        spurious;

  int checks = 0;
  int errors = 0;

  // Reference model state, kept as plain per-source flags.
  bit  m_srcq [32];
  bit  m_pend [32];
  bit  m_busy;      // a request is being presented
  bit  m_gap;       // the cycle after a retired request
  int  m_id;
  bit  m_spur;
  logic [31:0] edge_cfg;

  riscv_irq_ctrl #(.N_SRC(N), .EDGE_MASK(EDGE)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .src_i        (src),
    .mask_i       (mask),
    .irq_o        (irq),
    .irq_id_o     (irq_id),
    .irq_ack_i    (ack),
    .irq_ack_id_i (ack_id),
    .pending_o    (pending),
    .spurious_o   (spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m_pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_srcq[i] = 1'b0;
      m_pend[i] = 1'b0;
    end
    m_busy = 1'b0;
    m_gap  = 1'b0;
    m_id   = 0;
    m_spur = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit nxt [32];
    bit retire;
    int win;
    if (!rst_n) begin
      model_clear();
      return;
    end
    retire = ack && m_busy && (int'(ack_id) == m_id);
    for (int i = 0; i < 32; i++) begin
      nxt[i] = m_pend[i];
      if (ack && int'(ack_id) == i) nxt[i] = 1'b0;
      if (edge_cfg[i] ? (src[i] && !m_srcq[i]) : src[i]) nxt[i] = 1'b1;
    end
    if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_busy) begin
      if (retire) begin
        m_busy = 1'b0;
        m_gap  = 1'b1;
      end else if (!mask[m_id]) begin
        m_busy = 1'b0;
      end
    end else begin
      win = -1;
      for (int i = 0; i < 32; i++)
        if (win < 0 && m_pend[i] && mask[i]) win = i;
      if (win >= 0) begin
        m_busy = 1'b1;
        m_id   = win;
      end
    end
    m_spur = ack && !retire;
    for (int i = 0; i < 32; i++) begin
      m_pend[i] = nxt[i];
      m_srcq[i] = src[i];
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    src = '0; mask = '1; ack = 1'b0; ack_id = '0;
    model_clear();
    tick();
    checks++;
    if (irq !== 1'b0 || irq_id !== 5'd0 || pending !== 32'h0 || spurious !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got irq=%b id=%0d pend=%h spur=%b want all zero",
               irq, irq_id, pending, spurious);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_edge_single();
    src = 32'h0000_0008;
    tick();
    src = '0;
    checks++;
    if (pending[3] !== 1'b1 || irq !== 1'b0) begin
      errors++;
      $display("FAIL edge_pend got pend3=%b irq=%b want 1 0", pending[3], irq);
    end
    tick();
    checks++;
    if (irq !== 1'b1 || irq_id !== 5'd3) begin
      errors++;
      $display("FAIL edge_req got irq=%b id=%0d want 1 3", irq, irq_id);
    end
    ack = 1'b1; ack_id = 5'd3;
    tick();
    ack = 1'b0;
    checks++;
    if (irq !== 1'b0 || pending[3] !== 1'b0 || spurious !== 1'b0) begin
      errors++;
      $display("FAIL edge_ack got irq=%b pend3=%b spur=%b want 0 0 0", irq, pending[3], spurious);
    end
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    src = 32'h0000_0084;
    tick();
    src = '0;
    tick();
    checks++;
    if (irq !== 1'b1 || irq_id !== 5'd2) begin
      errors++;
      $display("FAIL b2b_first got irq=%b id=%0d want 1 2", irq, irq_id);
    end
    ack = 1'b1; ack_id = 5'd2;
    tick();
    ack = 1'b0;
    checks++;
    if (irq !== 1'b0 || pending !== 32'h0000_0080) begin
      errors++;
      $display("FAIL b2b_gap got irq=%b pend=%h want 0 00000080", irq, pending);
    end
    tick();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got irq=%b want 0", irq);
    end
    tick();
    checks++;
    if (irq !== 1'b1 || irq_id !== 5'd7) begin
      errors++;
      $display("FAIL b2b_second got irq=%b id=%0d want 1 7", irq, irq_id);
    end
    ack = 1'b1; ack_id = 5'd7;
    tick();
    ack = 1'b0;
    tick(); tick();
    checks++;
    if (irq !== 1'b0 || pending !== 32'h0) begin
      errors++;
      $display("FAIL b2b_drain got irq=%b pend=%h want 0 0", irq, pending);
    end
  endtask

  task automatic test_id_stable();
    src = 32'h0000_0200;
    tick();
    src = '0;
    tick();
    src = 32'h0000_0002;
    tick();
    src = '0;
    checks++;
    if (irq !== 1'b1 || irq_id !== 5'd9 || pending[1] !== 1'b1) begin
      errors++;
      $display("FAIL stable_hold got irq=%b id=%0d pend1=%b want 1 9 1", irq, irq_id, pending[1]);
    end
    tick();
    checks++;
    if (irq_id !== 5'd9) begin
      errors++;
      $display("FAIL stable_hold2 got id=%0d want 9", irq_id);
    end
    ack = 1'b1; ack_id = 5'd9;
    tick();
    ack = 1'b0;
    tick(); tick();
    checks++;
    if (irq !== 1'b1 || irq_id !== 5'd1) begin
      errors++;
      $display("FAIL stable_next got irq=%b id=%0d want 1 1", irq, irq_id);
    end
    ack = 1'b1; ack_id = 5'd1;
    tick();
    ack = 1'b0;
    tick(); tick();
  endtask

  task automatic test_retract();
    src = 32'h0000_0020;
    tick();
    src = '0;
    tick();
    mask = 32'hFFFF_FFDF;
    tick();
    checks++;
    if (irq !== 1'b0 || pending[5] !== 1'b1) begin
      errors++;
      $display("FAIL retract got irq=%b pend5=%b want 0 1", irq, pending[5]);
    end
    tick();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL retract_masked got irq=%b want 0", irq);
    end
    mask = '1;
    tick();
    checks++;
    if (irq !== 1'b1 || irq_id !== 5'd5) begin
      errors++;
      $display("FAIL retract_reissue got irq=%b id=%0d want 1 5", irq, irq_id);
    end
    ack = 1'b1; ack_id = 5'd5;
    tick();
    ack = 1'b0;
    tick(); tick();
  endtask

  task automatic test_spurious();
    src = 32'h0000_0040;
    tick();
    src = '0;
    tick();
    src = 32'h0000_0010;
    tick();
    src = '0;
    ack = 1'b1; ack_id = 5'd4;
    tick();
    ack = 1'b0;
    checks++;
    if (spurious !== 1'b1 || pending[4] !== 1'b0 || irq !== 1'b1 || irq_id !== 5'd6) begin
      errors++;
      $display("FAIL spurious got spur=%b pend4=%b irq=%b id=%0d want 1 0 1 6",
               spurious, pending[4], irq, irq_id);
    end
    tick();
    checks++;
    if (spurious !== 1'b0 || irq !== 1'b1) begin
      errors++;
      $display("FAIL spurious_pulse got spur=%b irq=%b want 0 1", spurious, irq);
    end
    ack = 1'b1; ack_id = 5'd6;
    tick();
    ack = 1'b0;
    tick(); tick();
  endtask

  task automatic test_level_and_reset();
    src = 32'h0000_0001;
    tick(); tick();
    checks++;
    if (irq !== 1'b1 || irq_id !== 5'd0) begin
      errors++;
      $display("FAIL level_req got irq=%b id=%0d want 1 0", irq, irq_id);
    end
    ack = 1'b1; ack_id = 5'd0;
    tick();
    ack = 1'b0;
    checks++;
    if (irq !== 1'b0 || pending[0] !== 1'b1) begin
      errors++;
      $display("FAIL level_repend got irq=%b pend0=%b want 0 1", irq, pending[0]);
    end
    tick(); tick();
    checks++;
    if (irq !== 1'b1 || irq_id !== 5'd0) begin
      errors++;
      $display("FAIL level_reissue got irq=%b id=%0d want 1 0", irq, irq_id);
    end
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (irq !== 1'b0 || irq_id !== 5'd0 || pending !== 32'h0 || spurious !== 1'b0) begin
      errors++;
      $display("FAIL midreq_reset got irq=%b id=%0d pend=%h spur=%b want all zero",
               irq, irq_id, pending, spurious);
    end
    src = 32'h0000_0400;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (pending !== 32'h0000_0400) begin
      errors++;
      $display("FAIL held_edge_after_reset got pend=%h want 00000400", pending);
    end
    tick();
    ack = 1'b1; ack_id = 5'd10;
    tick();
    ack = 1'b0;
    tick(); tick();
    checks++;
    if (pending[10] !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL held_edge_no_repend got pend10=%b irq=%b want 0 0", pending[10], irq);
    end
    src = '0;
    tick(); tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      src  = $urandom & $urandom & $urandom;
      mask = ~($urandom & $urandom & $urandom);
      ack  = 1'b0;
      ack_id = 5'($urandom_range(0, 31));
      if (m_busy && ($urandom_range(0, 2) == 0)) begin
        ack = 1'b1;
        if ($urandom_range(0, 4) != 0) ack_id = 5'(m_id);
      end else if ($urandom_range(0, 19) == 0) begin
        ack = 1'b1;
      end
      tick();
      checks++;
      if (irq !== m_busy || (m_busy && irq_id !== 5'(m_id)) ||
          pending !== m_pend_vec() || spurious !== m_spur) begin
        errors++;
        $display("FAIL random_cycle%0d got irq=%b id=%0d pend=%h spur=%b want irq=%b id=%0d pend=%h spur=%b",
                 c, irq, irq_id, pending, spurious, m_busy, m_id, m_pend_vec(), m_spur);
      end
    end
    src = '0; mask = '1; ack = 1'b0;
  endtask

  initial begin
    edge_cfg = EDGE;
    test_reset();
    test_edge_single();
    test_back_to_back();
    test_id_stable();
    test_retract();
    test_spurious();
    test_level_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
